// File: rtl/ddr_out_reg_pkg.sv
// Shared constants for the single-bit output DDR register.
// DDR_CLK_EDGE accepts one of these two strings:
//   OPPOSITE_EDGE : D1 is sampled on the rising edge of C, D2 on the falling edge.
//   SAME_EDGE     : D1 and D2 are both sampled on the rising edge of C.
package ddr_out_reg_pkg;

    localparam string OPPOSITE_EDGE = "OPPOSITE_EDGE";
    localparam string SAME_EDGE     = "SAME_EDGE";

endpackage : ddr_out_reg_pkg

// File: rtl/ddr_out_reg.sv
// Single-bit output double-data-rate register, a behavioural equivalent of
// the FPGA output DDR primitive. Q carries D1 during the high half of C and
// D2 during the low half, so the pin moves two bits per clock period.
//
// Ports:
//   C  - clock; both edges are used
//   R  - asynchronous active-high reset; forces Q to 0 and has top priority
//   CE - clock enable, active-high; when low, no flop updates on either edge
//   D1 - data driven onto Q at the rising edge of C
//   D2 - data driven onto Q at the falling edge of C
//   S  - synchronous active-high set; forces Q to 1 at the next edge of C
//        regardless of CE
//   Q  - DDR output
module ddr_out_reg
    import ddr_out_reg_pkg::*;
#(
    parameter string DDR_CLK_EDGE = OPPOSITE_EDGE,
    parameter bit    INIT         = 1'b0
) (
    input  logic C,
    input  logic R,
    input  logic CE,
    input  logic D1,
    input  logic D2,
    input  logic S,
    output logic Q
);

    localparam bit SAME_MODE  = (DDR_CLK_EDGE == SAME_EDGE);
    localparam bit MODE_VALID = SAME_MODE || (DDR_CLK_EDGE == OPPOSITE_EDGE);

    // Reject an unknown capture mode at elaboration time.
    generate
        if (!MODE_VALID) begin : g_bad_mode
            $error("ddr_out_reg: DDR_CLK_EDGE must be OPPOSITE_EDGE or SAME_EDGE");
        end
    endgenerate

    // Q is the XOR of a rising-edge flop and a falling-edge flop. Each edge
    // updates only its own flop, so Q changes exactly once per edge with no
    // mux on the clock level and no glitch. The initial values below are the
    // power-up state of the flops and give Q = INIT before any edge or reset.
    logic r_rise = INIT;
    logic r_fall = 1'b0;
    logic r_hold = INIT;
    logic w_fall_data;

    // Rising-edge flop: writes D1 onto Q. The hold flop captures D2 here for SAME_EDGE.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            r_rise <= 1'b0;
            r_hold <= 1'b0;
        end else if (S) begin
            r_rise <= ~r_fall;
            r_hold <= 1'b1;
        end else if (CE) begin
            r_rise <= D1 ^ r_fall;
            r_hold <= D2;
        end
    end

    // SAME_EDGE ignores any D2 change made after the rising edge.
    assign w_fall_data = SAME_MODE ? r_hold : D2;

    // Falling-edge flop: writes the selected D2 value onto Q.
    always_ff @(negedge C or posedge R) begin
        if (R) begin
            r_fall <= 1'b0;
        end else if (S) begin
            r_fall <= ~r_rise;
        end else if (CE) begin
            r_fall <= w_fall_data ^ r_rise;
        end
    end

    assign Q = r_rise ^ r_fall;

endmodule : ddr_out_reg

// File: tb/tb_ddr_out_reg.sv
// Self-checking bench for ddr_out_reg. Instance a is OPPOSITE_EDGE with
// INIT=1, and instance b is SAME_EDGE with INIT=0. A reference model
// tracks the value Q must hold after every edge and every reset assertion.
// A compare process checks both instances 1 time unit after every clock
// edge. Directed phases pin the model with literal expectations, and a
// randomized phase then exercises all input combinations.
`timescale 1ns/1ps
module tb_ddr_out_reg;
    import ddr_out_reg_pkg::*;

    logic C = 1'b0;
    logic ra = 1'b0, sa = 1'b0, cea = 1'b0, d1a = 1'b0, d2a = 1'b0, qa;
    logic rb = 1'b0, sb = 1'b0, ceb = 1'b0, d1b = 1'b0, d2b = 1'b0, qb;

    int checks = 0;
    int errors = 0;

    // Model state: the required Q of each instance and b's captured D2.
    logic mqa   = 1'b1;
    logic mqb   = 1'b0;
    logic holdb = 1'b0;
    logic c_prev = 1'b0;

    ddr_out_reg #(.DDR_CLK_EDGE(OPPOSITE_EDGE), .INIT(1'b1)) u_dut_a (
        .C(C), .R(ra), .CE(cea), .D1(d1a), .D2(d2a), .S(sa), .Q(qa)
    );

    ddr_out_reg #(.DDR_CLK_EDGE(SAME_EDGE), .INIT(1'b0)) u_dut_b (
        .C(C), .R(rb), .CE(ceb), .D1(d1b), .D2(d2b), .S(sb), .Q(qb)
    );

    always #5 C = ~C;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: the rules for each edge are applied directly, and a
    // rising R clears the state at once.
    always @(posedge C or negedge C or posedge ra or posedge rb) begin
        if (C !== c_prev) begin
            c_prev = C;
            if (C) begin
                if (ra) mqa = 1'b0;
                else if (sa) mqa = 1'b1;
                else if (cea) mqa = d1a;
                if (rb) begin mqb = 1'b0; holdb = 1'b0; end
                else if (sb) begin mqb = 1'b1; holdb = 1'b1; end
                else if (ceb) begin mqb = d1b; holdb = d2b; end
            end else begin
                if (ra) mqa = 1'b0;
                else if (sa) mqa = 1'b1;
                else if (cea) mqa = d2a;
                if (rb) mqb = 1'b0;
                else if (sb) mqb = 1'b1;
                else if (ceb) mqb = holdb;
            end
        end
        if (ra) mqa = 1'b0;
        if (rb) begin mqb = 1'b0; holdb = 1'b0; end
    end

    // Continuous comparison against the model after every edge.
    always @(C) begin
        #1;
        check("model_a", qa, mqa);
        check("model_b", qb, mqb);
    end

    logic exp_nib [4];

    initial begin
        exp_nib[0] = 1'b1; exp_nib[1] = 1'b0; exp_nib[2] = 1'b0; exp_nib[3] = 1'b1;

        // Power-up values before any edge.
        #1;
        check("pwrup_a", qa, 1'b1);
        check("pwrup_b", qb, 1'b0);

        // Reset clears Q immediately, with no clock edge.
        #1 ra = 1'b1;
        #1 check("rst_imm", qa, 1'b0);

        // Release reset after the first rising edge and forward the clock.
        @(posedge C); #2;
        ra = 1'b0; cea = 1'b1; d1a = 1'b1; d2a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(C); #1;
            check("fwd_eq_c", qa, C);
        end
        d1a = 1'b0; d2a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(C); #1;
            check("fwd_inv_c", qa, ~C);
        end

        // Nibble mapping: the Q values at edges r,f,r,f are 1,0,0,1.
        @(negedge C); #2;
        d1a = 1'b1; d2a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(C); #1;
            check("nibble", qa, exp_nib[i]);
            if (i == 1) begin d1a = 1'b0; d2a = 1'b1; end
        end

        // Clock enable low holds Q=1 while D1 and D2 toggle.
        #1 d1a = 1'b1;
        @(posedge C); #1;
        check("ce_pre", qa, 1'b1);
        #1 cea = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d1a = ~d1a; d2a = ~d2a;
            @(C); #1;
            check("ce_hold", qa, 1'b1);
            #1;
        end
        cea = 1'b1; d1a = 1'b0; d2a = 1'b0;
        @(C); #1;
        check("ce_resume", qa, 1'b0);

        // Set with CE low, then reset overriding set, then set after release.
        #1 sa = 1'b1; cea = 1'b0;
        @(C); #1;
        check("set_edge", qa, 1'b1);
        #1 ra = 1'b1;
        #1 check("rs_imm", qa, 1'b0);
        @(C); #2;
        check("rs_hold", qa, 1'b0);
        ra = 1'b0;
        @(C); #1;
        check("set_after_rst", qa, 1'b1);
        #1 sa = 1'b0; cea = 1'b1;

        // SAME_EDGE: a change to D2 during the high phase does not reach Q.
        @(negedge C); #2;
        ceb = 1'b1; d1b = 1'b1; d2b = 1'b1;
        @(posedge C); #1;
        check("same_rise", qb, 1'b1);
        #1 d2b = 1'b0;
        @(negedge C); #1;
        check("same_fall_held1", qb, 1'b1);
        #1 d1b = 1'b0; d2b = 1'b0;
        @(posedge C); #1;
        check("same_rise0", qb, 1'b0);
        #1 d2b = 1'b1;
        @(negedge C); #1;
        check("same_fall_held0", qb, 1'b0);

        // Randomized phase, checked by the model on every edge.
        for (int i = 0; i < 3000; i++) begin
            @(C); #2;
            ra  = ($urandom_range(15) == 0);
            sa  = ($urandom_range(7) == 0);
            cea = ($urandom_range(3) != 0);
            d1a = 1'($urandom_range(1));
            d2a = 1'($urandom_range(1));
            rb  = ($urandom_range(15) == 0);
            sb  = ($urandom_range(7) == 0);
            ceb = ($urandom_range(3) != 0);
            d1b = 1'($urandom_range(1));
            d2b = 1'($urandom_range(1));
        end
        @(C); #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ddr_out_reg

// File: doc/ddr_out_reg.md
Name: ddr_out_reg

Overview:
- Single-bit output double-data-rate register, a behavioural equivalent of the FPGA output DDR primitive.
- Drives D1 on the rising half of C and D2 on the falling half, so one pin carries two bits per clock period.
- The RGMII transmit path uses one instance per data nibble bit, one for TX_CTL, and one with D1=1/D2=0 to forward the clock.

Parameters:
- DDR_CLK_EDGE, "OPPOSITE_EDGE", capture mode. "OPPOSITE_EDGE": D1 is sampled on the rising edge of C and D2 on the falling edge. "SAME_EDGE": both are sampled on the rising edge. Any other value is an elaboration error.
- INIT, 1'b0, power-up value of Q and of the internal capture flops.

Ports:
- C  input  1  clock; both edges are used.
- R  input  1  asynchronous active-high reset, forces Q=0.
- Q  output 1  DDR output.
- CE  input  1  clock enable, active-high.
- D1  input  1  data for the rising-edge (high) half of C.
- D2  input  1  data for the falling-edge (low) half of C.
- S  input  1  synchronous active-high set, forces Q=1.

Behaviour:
- Power-up (before any reset or edge): Q = INIT; all internal flops = INIT.
- Reset R=1:
  - Q and all internal flops go to 0 immediately, independent of C.
  - They hold 0 while R=1.
  - R has priority over S and CE.
  - After release, Q keeps 0 until the next enabled edge.
- Set S=1 (with R=0):
  - At the next edge of C (rising or falling), Q and all internal flops become 1.
  - S is evaluated on every edge of C, regardless of CE.
- Enable CE=0 (R=0, S=0): no flop updates on either edge; Q holds its last value.
- Normal operation, OPPOSITE_EDGE mode (R=0, S=0, CE=1):
  - Rising edge of C: Q <= D1.
  - Falling edge of C: Q <= D2, sampled at that falling edge.
  - Latency is 0 cycles from the sampling edge; Q changes only on edges.
- Normal operation, SAME_EDGE mode (R=0, S=0, CE=1):
  - Rising edge of C: Q <= D1, and D2 is captured into a hold flop at the same instant.
  - Following falling edge: Q <= held D2.
  - D2 changes between the rising and falling edge must not affect Q.
- Q is a registered output only; it must not combinationally follow D1 or D2.
- Clock forwarding: D1=1, D2=0, CE=1 gives Q as a copy of C, both edges aligned with C.
- Simultaneous events:
  - R asserted at the same instant as an edge: Q=0.
  - R deasserted at an edge: that edge is ignored and Q stays 0.
  - CE changing at an edge: the CE value just before the edge applies.
- Implementation:
  - Use separate rising-edge and falling-edge flops with a registered output selection. Do not mux on the clock level.
  - Q must be glitch-free at each edge in simulation.

Decomposition:
- Shared package holds the edge-mode string constants: OPPOSITE_EDGE, SAME_EDGE.
- No sub-module; the block is a leaf.

Test Plan:
- Power-up, INIT=1: before any edge -> Q=1. Assert R -> Q=0 immediately, no clock edge needed.
- OPPOSITE_EDGE, CE=1: D1=1/D2=0 for 3 cycles, then D1=0/D2=1 for 3 cycles -> Q high during the high phases then low phases (equals C), then Q = ~C.
- OPPOSITE_EDGE: nibble mapping with D1=TxD[0]=1, D2=TxD[4]=0, then 0/1 -> Q sequence at edges r,f,r,f = 1,0,0,1.
- SAME_EDGE: D1=1, D2=1 at the rising edge; D2 toggled to 0 mid-high-phase -> Q=1 at the rising edge and still 1 at the falling edge.
- CE=0 after Q=1 from D1, with D1/D2 toggling for 4 edges -> Q stays 1. Restore CE=1 -> Q resumes following D1/D2 on the next edge.
- S=1, R=0, CE=0 -> Q=1 at the next edge. S=1 and R=1 together -> Q=0 immediately. Release R mid-cycle with S=1 -> Q=1 at the next edge.
